act_slice_feeder: RTL and testbench

ACT_SLICE_FEEDER -- requirements
Module: act_slice_feeder

---
 rtl/act_slice_feeder.sv | 143 ++++++++++++++
 tb/tb_act_slice_feeder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/act_slice_feeder.sv
// Bit-serial activation feeder: holds one quantized vector and emits it as 2-bit slices, LSB first.
// Optional zero-vector skipping is enabled by defining ACT_FEED_ZERO_SKIP_EN.

module act_slice_lane #(
    parameter int ACT_WIDTH = 8
) (
    input  logic [ACT_WIDTH-1:0] act,
    input  logic [1:0]           idx,
    input  logic                 en,
    output logic [1:0]           slice
);
    always_comb begin
        slice = 2'b00;
        if (en) begin
            case (idx)
                2'd0: slice = act[1:0];
                2'd1: slice = act[3:2];
                2'd2: slice = act[5:4];
                default: slice = act[7:6];
            endcase
        end
    end
endmodule

module act_slice_feeder #(
    parameter int MAX_INPUT_WIDTH = 16,
    parameter int ACT_WIDTH       = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ACT_WIDTH*MAX_INPUT_WIDTH-1:0] din,
    input  logic [1:0]                           fmap_precision,
    input  logic                                 vld_i,
    output logic                                 rdy_o,
    output logic [2*MAX_INPUT_WIDTH-1:0]         slice_o,
    output logic [1:0]                           slice_idx,
    output logic                                 msb_o,
    output logic                                 vld_o,
    input  logic                                 rdy_i,
    output logic [15:0]                          skip_cnt
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [1:0] n_last;
    logic [1:0] n_last_new;
    logic [ACT_WIDTH*MAX_INPUT_WIDTH-1:0] held;
    logic last, xfer, accept, zero_drop, load;

    always_comb begin
        case (fmap_precision)
            2'd0:    n_last_new = 2'd0;
            2'd1:    n_last_new = 2'd1;
            default: n_last_new = 2'd3;
        endcase
    end

    assign vld_o  = (state == STREAM);
    assign last   = (idx == n_last);
    assign xfer   = vld_o && rdy_i;
    assign rdy_o  = (state == IDLE) || (last && rdy_i);
    assign accept = vld_i && rdy_o;

`ifdef ACT_FEED_ZERO_SKIP_EN
    assign zero_drop = accept && (din == '0);
`else
    assign zero_drop = 1'b0;
`endif
    assign load = accept && !zero_drop;

    // A load in STREAM only happens on the last-slice transfer, so it always restarts at slice 0.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = STREAM;
                    idx_nxt   = 2'd0;
                end
            end
            STREAM: begin
                if (load) begin
                    state_nxt = STREAM;
                    idx_nxt   = 2'd0;
                end else if (xfer && !last) begin
                    idx_nxt = idx + 2'd1;
                end else if (xfer) begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held   <= '0;
            n_last <= 2'd0;
        end else if (load) begin
            held   <= din;
            n_last <= n_last_new;
        end
    end

`ifdef ACT_FEED_ZERO_SKIP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skip_cnt <= 16'd0;
        else if (zero_drop && skip_cnt != 16'hFFFF)
            skip_cnt <= skip_cnt + 16'd1;
    end
`else
    assign skip_cnt = 16'd0;
`endif

    assign slice_idx = idx;
    assign msb_o     = vld_o && last;

    for (genvar g = 0; g < MAX_INPUT_WIDTH; g++) begin : g_lane
        act_slice_lane #(.ACT_WIDTH(ACT_WIDTH)) u_lane (
            .act   (held[g*ACT_WIDTH +: ACT_WIDTH]),
            .idx   (idx),
            .en    (vld_o),
            .slice (slice_o[g*2 +: 2])
        );
    end
endmodule

// File: tb/tb_act_slice_feeder.sv
// Directed table-driven bench for act_slice_feeder; lane 0 and the remaining lanes carry separate bytes.
`timescale 1ns/1ps
module tb_act_slice_feeder;
    localparam int L = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [8*L-1:0]   din;
    logic [1:0]       fmap_precision;
    logic             vld_i, rdy_o, msb_o, vld_o, rdy_i;
    logic [2*L-1:0]   slice_o;
    logic [1:0]       slice_idx;
    logic [15:0]      skip_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    act_slice_feeder #(.MAX_INPUT_WIDTH(L), .ACT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .din(din), .fmap_precision(fmap_precision),
        .vld_i(vld_i), .rdy_o(rdy_o), .slice_o(slice_o), .slice_idx(slice_idx),
        .msb_o(msb_o), .vld_o(vld_o), .rdy_i(rdy_i), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       vld;
        logic [1:0] prec;
        logic [7:0] d0;
        logic [7:0] dr;
        logic       rdy;
        logic       e_vld;
        logic [1:0] e_s0;
        logic [1:0] e_sr;
        logic [1:0] e_idx;
        logic       e_msb;
        logic       e_rdy;
    } row_t;

    row_t tbl[$];
    row_t zs[$];

    function automatic row_t mk(input logic v, input logic [1:0] p, input logic [7:0] a,
                                input logic [7:0] b, input logic r, input logic ev,
                                input logic [1:0] s0, input logic [1:0] sr, input logic [1:0] ei,
                                input logic em, input logic er);
        row_t x;
        x = '{vld:v, prec:p, d0:a, dr:b, rdy:r, e_vld:ev, e_s0:s0, e_sr:sr,
              e_idx:ei, e_msb:em, e_rdy:er};
        return x;
    endfunction

    function automatic row_t idle_row(input logic v, input logic [1:0] p,
                                      input logic [7:0] a, input logic [7:0] b);
        return mk(v, p, a, b, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input row_t r, input string tag);
        logic [2*L-1:0] es;
        @(negedge clk);
        vld_i = r.vld; fmap_precision = r.prec; rdy_i = r.rdy;
        din = {{(L-1){r.dr}}, r.d0};
        #1;
        es = {{(L-1){r.e_sr}}, r.e_s0};
        check({tag, ".vld_o"},     32'(vld_o),     32'(r.e_vld));
        check({tag, ".slice_o"},   32'(slice_o),   32'(es));
        check({tag, ".slice_idx"}, 32'(slice_idx), 32'(r.e_idx));
        check({tag, ".msb_o"},     32'(msb_o),     32'(r.e_msb));
        check({tag, ".rdy_o"},     32'(rdy_o),     32'(r.e_rdy));
    endtask

    initial begin
        rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; fmap_precision = 2'd0; din = '0;

        // 8b, all lanes 0xB4 (lane0) / 0xB4
        tbl.push_back(idle_row(1, 2, 8'hB4, 8'hB4));
        tbl.push_back(mk(0, 2, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 1, 1, 2'd1, 2'd1, 2'd1, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 1, 1, 2'd3, 2'd3, 2'd2, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 1, 1, 2'd2, 2'd2, 2'd3, 1, 1));
        tbl.push_back(idle_row(0, 2, 0, 0));
        // 2b back-to-back, no bubbles
        tbl.push_back(idle_row(1, 0, 8'h03, 8'h01));
        tbl.push_back(mk(1, 0, 8'h02, 8'h03, 1, 1, 2'd3, 2'd1, 2'd0, 1, 1));
        tbl.push_back(mk(1, 0, 8'h01, 8'h02, 1, 1, 2'd2, 2'd3, 2'd0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2'd1, 2'd2, 2'd0, 1, 1));
        tbl.push_back(idle_row(0, 0, 0, 0));
        // 4b with 3-cycle stall at idx 0
        tbl.push_back(idle_row(1, 1, 8'h0E, 8'h07));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 2'd2, 2'd3, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 2'd2, 2'd3, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 2'd2, 2'd3, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 2'd2, 2'd3, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 2'd3, 2'd1, 2'd1, 1, 1));
        tbl.push_back(idle_row(0, 1, 0, 0));
        // 8b held while precision/din change; stall on last slice; no-bubble reload at 2b
        tbl.push_back(idle_row(1, 2, 8'hE4, 8'h1B));
        tbl.push_back(mk(0, 2, 0, 0, 1, 1, 2'd0, 2'd3, 2'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 8'hFF, 1, 1, 2'd1, 2'd2, 2'd1, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 8'hFF, 1, 1, 2'd2, 2'd1, 2'd2, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 8'hFF, 0, 1, 2'd3, 2'd0, 2'd3, 1, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 8'hFF, 1, 1, 2'd3, 2'd0, 2'd3, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2'd3, 2'd3, 2'd0, 1, 1));
        tbl.push_back(idle_row(0, 0, 0, 0));

        // zero vector then all-0x01 at 2b
`ifdef ACT_FEED_ZERO_SKIP_EN
        zs.push_back(idle_row(1, 0, 8'h00, 8'h00));
        zs.push_back(idle_row(1, 0, 8'h01, 8'h01));
        zs.push_back(mk(0, 0, 0, 0, 1, 1, 2'd1, 2'd1, 2'd0, 1, 1));
        zs.push_back(idle_row(0, 0, 0, 0));
`else
        zs.push_back(idle_row(1, 0, 8'h00, 8'h00));
        zs.push_back(mk(1, 0, 8'h01, 8'h01, 1, 1, 2'd0, 2'd0, 2'd0, 1, 1));
        zs.push_back(mk(0, 0, 0, 0, 1, 1, 2'd1, 2'd1, 2'd0, 1, 1));
        zs.push_back(idle_row(0, 0, 0, 0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.vld_o", 32'(vld_o), 0);
        check("reset.slice_o", 32'(slice_o), 0);
        check("reset.slice_idx", 32'(slice_idx), 0);
        check("reset.msb_o", 32'(msb_o), 0);
        check("reset.rdy_o", 32'(rdy_o), 1);
        check("reset.skip_cnt", 32'(skip_cnt), 0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));
        check("tbl.skip_cnt", 32'(skip_cnt), 0);

        // Reset asserted mid-vector at idx 2 discards it
        apply(idle_row(1, 2, 8'hB4, 8'hB4), "rst_a");
        apply(mk(0, 2, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 0, 0), "rst_b");
        apply(mk(0, 2, 0, 0, 1, 1, 2'd1, 2'd1, 2'd1, 0, 0), "rst_c");
        apply(mk(0, 2, 0, 0, 1, 1, 2'd3, 2'd3, 2'd2, 0, 0), "rst_d");
        #1 rst = 1'b1;
        #1;
        check("rst_async.vld_o", 32'(vld_o), 0);
        check("rst_async.slice_o", 32'(slice_o), 0);
        check("rst_async.msb_o", 32'(msb_o), 0);
        check("rst_async.skip_cnt", 32'(skip_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) apply(idle_row(0, 2, 0, 0), $sformatf("rst_post%0d", k));

        foreach (zs[i]) apply(zs[i], $sformatf("zs%0d", i));
`ifdef ACT_FEED_ZERO_SKIP_EN
        check("zs.skip_cnt", 32'(skip_cnt), 1);
`else
        check("zs.skip_cnt", 32'(skip_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
